// File: rtl/object_display_ctrl.sv
// Shape/full-screen sequencer for the VGA object generators: debounces two
// pushbuttons and commits their requests once per frame at the start of vertical blanking.
module object_display_ctrl #(
  parameter logic [15:0] DB_CYCLES  = 16'd50000,
  parameter logic [9:0]  V_ACTIVE   = 10'd480,
  parameter logic [1:0]  NUM_SHAPES = 2'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] HCount,
  input  logic [9:0] VCount,
  input  logic       btn_next,
  input  logic       btn_full,
  output logic       square_select,
  output logic       circle_select,
  output logic       triangle_select,
  output logic       full_screen,
  output logic       frame_update,
  output logic       pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VB = 2'd1,
    COMMIT  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;

  // Bit 0 carries the "next shape" button, bit 1 the "full screen" button.
  logic [1:0]  btn_raw;
  logic [1:0]  sync_p0;
  logic [1:0]  sync_p1;
  logic [1:0]  db_lvl;
  logic [1:0]  db_done;
  logic [1:0]  db_rise;
  logic [15:0] db_cnt [2];

  logic        req_next;
  logic        req_full;
  logic        upd_cond;
  logic        commit;
  logic [1:0]  shape_idx;
  logic [1:0]  idx_nxt;

  // Out-of-range indices fall back to square on any commit, advance or not.
  function automatic logic [1:0] next_shape(input logic [1:0] idx, input logic adv);
    if (idx >= NUM_SHAPES) return 2'd0;
    if (!adv) return idx;
    return (idx == NUM_SHAPES - 2'd1) ? 2'd0 : idx + 2'd1;
  endfunction

  assign btn_raw  = {btn_full, btn_next};
  assign upd_cond = (VCount == V_ACTIVE) && (HCount == 10'd0);
  assign commit   = (state_q == COMMIT);

  // Stage p0/p1: two-flop synchronizer ahead of the debouncers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_p0 <= 2'b00;
      sync_p1 <= 2'b00;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  always_comb begin
    db_done = 2'b00;
    db_rise = 2'b00;
    for (int b = 0; b < 2; b++) begin
      db_done[b] = (sync_p1[b] != db_lvl[b]) && (db_cnt[b] == DB_CYCLES - 16'd1);
      db_rise[b] = db_done[b] & sync_p1[b];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      db_lvl <= 2'b00;
      for (int b = 0; b < 2; b++) db_cnt[b] <= 16'd0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (sync_p1[b] == db_lvl[b]) begin
          db_cnt[b] <= 16'd0;
        end else if (db_done[b]) begin
          db_lvl[b] <= sync_p1[b];
          db_cnt[b] <= 16'd0;
        end else begin
          db_cnt[b] <= db_cnt[b] + 16'd1;
        end
      end
    end
  end

  // A debounced rising edge wins over the commit clear so a press landing
  // in the commit cycle carries into the next frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      req_next <= 1'b0;
      req_full <= 1'b0;
      pending  <= 1'b0;
    end else begin
      if (db_rise[0])  req_next <= 1'b1;
      else if (commit) req_next <= 1'b0;
      if (db_rise[1])  req_full <= 1'b1;
      else if (commit) req_full <= 1'b0;
      pending <= req_next | req_full;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // HOLD waits out the whole update point so a multi-clock HCount==0 cannot
  // produce a second commit in the same frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pending)   state_d = WAIT_VB;
      WAIT_VB: if (upd_cond)  state_d = COMMIT;
      COMMIT:                 state_d = HOLD;
      HOLD:    if (!upd_cond) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_nxt = shape_idx;
    if (commit) idx_nxt = next_shape(shape_idx, req_next);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shape_idx       <= 2'd0;
      square_select   <= 1'b1;
      circle_select   <= 1'b0;
      triangle_select <= 1'b0;
      full_screen     <= 1'b0;
      frame_update    <= 1'b0;
    end else begin
      shape_idx       <= idx_nxt;
      square_select   <= (idx_nxt != 2'd1) && (idx_nxt != 2'd2);
      circle_select   <= (idx_nxt == 2'd1);
      triangle_select <= (idx_nxt == 2'd2);
      frame_update    <= commit;
      if (commit && req_full) full_screen <= ~full_screen;
    end
  end

endmodule

// File: tb/tb_object_display_ctrl.sv
// Bench for object_display_ctrl: directed scenarios plus random press patterns
// per compressed frame, checked against a per-frame request/commit model.
module tb_object_display_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] HCount;
  logic [9:0] VCount;
  logic       btn_next;
  logic       btn_full;
  logic       square_select;
  logic       circle_select;
  logic       triangle_select;
  logic       full_screen;
  logic       frame_update;
  logic       pending;

  int vectors     = 0;
  int miscompares = 0;
  int pulse_cnt   = 0;

  // Frame-level model: current shape number, full-screen mode, and whether
  // a qualified press of each button happened since the last commit.
  int m_idx;
  bit m_full;
  bit m_req_next;
  bit m_req_full;

  always #5 clk = ~clk;

  object_display_ctrl #(
    .DB_CYCLES (16'd4),
    .V_ACTIVE  (10'd480),
    .NUM_SHAPES(2'd3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .HCount         (HCount),
    .VCount         (VCount),
    .btn_next       (btn_next),
    .btn_full       (btn_full),
    .square_select  (square_select),
    .circle_select  (circle_select),
    .triangle_select(triangle_select),
    .full_screen    (full_screen),
    .frame_update   (frame_update),
    .pending        (pending)
  );

  always @(negedge clk) if (frame_update === 1'b1) pulse_cnt++;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] sel_of(input int idx);
    logic [2:0] one;
    one = 3'b001;
    return one << idx;
  endfunction

  task automatic chk_outputs(input string tag);
    chk({tag, "_sel"}, {13'd0, triangle_select, circle_select, square_select},
        {13'd0, sel_of(m_idx)});
    chk({tag, "_full"}, {15'd0, full_screen}, {15'd0, m_full});
  endtask

  task automatic model_reset();
    m_idx      = 0;
    m_full     = 1'b0;
    m_req_next = 1'b0;
    m_req_full = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    tick(n);
    reset = 1'b1;
    tick(1);
    model_reset();
  endtask

  // Holds one button high for len clocks, then low long enough for the
  // debouncer to settle back before any following press.
  task automatic press(input bit which_full, input int len);
    if (which_full) btn_full = 1'b1;
    else            btn_next = 1'b1;
    tick(len);
    btn_next = 1'b0;
    btn_full = 1'b0;
    tick($urandom_range(6, 9));
  endtask

  task automatic press_phase(input int n_next, input int n_full, input int n_glitch);
    for (int i = 0; i < n_next; i++) press(1'b0, $urandom_range(5, 10));
    for (int i = 0; i < n_full; i++) press(1'b1, $urandom_range(5, 10));
    for (int i = 0; i < n_glitch; i++) press(1'($urandom_range(0, 1)), $urandom_range(1, 3));
    if (n_next > 0) m_req_next = 1'b1;
    if (n_full > 0) m_req_full = 1'b1;
    tick(4);
  endtask

  // Compressed blanking: the update point is held for k clocks, then the
  // counters move on so the controller can leave its hold state.
  task automatic update_phase(input string tag, input int k);
    int p0;
    bit any;
    chk_outputs({tag, "_pre"});
    chk({tag, "_pre_pend"}, {15'd0, pending}, {15'd0, (m_req_next | m_req_full)});
    p0 = pulse_cnt;
    VCount = 10'd480;
    HCount = 10'd0;
    tick(k);
    HCount = 10'd1;
    tick(3);
    VCount = 10'd481;
    HCount = 10'd0;
    tick(3);
    any = m_req_next | m_req_full;
    if (m_req_next) m_idx = (m_idx + 1) % 3;
    if (m_req_full) m_full = !m_full;
    m_req_next = 1'b0;
    m_req_full = 1'b0;
    chk({tag, "_pulses"}, 16'(pulse_cnt - p0), {15'd0, any});
    chk_outputs({tag, "_post"});
    chk({tag, "_post_pend"}, {15'd0, pending}, 16'd0);
    VCount = 10'd100;
    HCount = 10'd37;
    tick(2);
  endtask

  initial begin
    reset    = 1'b0;
    btn_next = 1'b0;
    btn_full = 1'b0;
    VCount   = 10'd100;
    HCount   = 10'd37;
    do_reset(3);
    chk_outputs("rst");
    chk("rst_pend", {15'd0, pending}, 16'd0);
    chk("rst_fu", {15'd0, frame_update}, 16'd0);
    update_phase("idle_frame", 1);

    btn_next = 1'b1;
    tick(7);
    chk("pend_latency", {15'd0, pending}, 16'd1);
    chk_outputs("no_early_change");
    tick(3);
    btn_next = 1'b0;
    tick(8);
    m_req_next = 1'b1;
    update_phase("single_next", 1);

    do_reset(2);
    press_phase(3, 0, 0);
    update_phase("coalesce", 1);
    for (int f = 0; f < 3; f++) begin
      press_phase(1, 0, 0);
      update_phase("advance", 1);
    end

    do_reset(2);
    press_phase(1, 1, 0);
    update_phase("both", 1);
    press_phase(0, 1, 0);
    update_phase("full_again", 1);

    press_phase(0, 0, 2);
    update_phase("glitch", 1);

    press_phase(1, 0, 0);
    update_phase("hold2", 2);

    press_phase(0, 1, 0);
    VCount = 10'd300;
    tick(2);
    do_reset(2);
    chk_outputs("rst_wait");
    chk("rst_wait_pend", {15'd0, pending}, 16'd0);
    update_phase("after_rst", 1);

    for (int f = 0; f < 12; f++) begin
      press_phase($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2));
      update_phase("rnd", $urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/object_display_ctrl.md
Name: object_display_ctrl

Overview:
- Sequences the VGA object generators (square, circle, triangle).
- Converts two raw pushbuttons into debounced requests: "next shape" and "toggle full screen".
- Commits requests only at the start of vertical blanking, so an object's geometry never changes mid-frame.
- Drives the per-object select lines and the shared full_screen line consumed by the object_* blocks.

Parameters:
- DB_CYCLES, 16'd50000: consecutive stable clocks required to accept a button level change (sim: 4).
- V_ACTIVE, 10'd480: first non-visible line; the update point is VCount==V_ACTIVE && HCount==0.
- NUM_SHAPES, 2'd3: number of selectable shapes; index wraps at NUM_SHAPES-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- HCount  in  10  current pixel column from the sync generator
- VCount  in  10  current line from the sync generator
- btn_next  in  1  raw, asynchronous pushbutton; advance shape
- btn_full  in  1  raw, asynchronous pushbutton; toggle full_screen
- square_select  out  1  registered; shape index==0
- circle_select  out  1  registered; shape index==1
- triangle_select  out  1  registered; shape index==2
- full_screen  out  1  registered full-screen mode
- frame_update  out  1  one-clock pulse on each commit cycle
- pending  out  1  high while any request awaits commit

Behaviour:
- Reset (reset==0 at a clk edge) sets:
  - shape index 0: square_select=1, circle_select=0, triangle_select=0
  - full_screen=0, frame_update=0, pending=0
  - FSM to IDLE
  - debounce counters 0; debounced levels 0
  - synchronizer flops 0
  - both request flags cleared
- Reset mid-operation discards pending requests with no commit.
- Input sync: each button passes through a 2-flop synchronizer; 2 cycles latency before the debouncer.
- Debouncer, one per button:
  - Counter clears whenever the synced level equals the debounced level.
  - Otherwise it increments. When it reaches DB_CYCLES-1, the debounced level takes the synced level and the counter clears.
  - Glitches shorter than DB_CYCLES never propagate.
- Request capture:
  - A rising edge of the debounced level sets req_next or req_full.
  - Multiple presses before a commit coalesce: at most one shape advance and one toggle per frame.
- pending = req_next | req_full, registered.
- Select outputs are one-hot from the shape index; exactly one is high at all times.
- FSM states:
  - IDLE: if pending -> WAIT_VB.
  - WAIT_VB: when VCount==V_ACTIVE && HCount==0 -> COMMIT.
  - COMMIT, exactly one clock:
    - If req_next: index = (index==NUM_SHAPES-1) ? 0 : index+1.
    - If req_full: full_screen toggles.
    - frame_update=1; both flags clear; -> HOLD.
  - HOLD: stays until the update condition is false (HCount can hold 0 for several clk at pixel-tick rate); then -> IDLE.
  - Guarantees at most one commit per frame.
- Both requests pending: both apply in the same COMMIT cycle.
- A request captured during COMMIT is not lost: set takes priority over clear. It commits next frame.
- A request arriving in HOLD or WAIT_VB is served at the next valid update point. There is no fast path inside the current blanking interval.
- Outputs change only on the clock edge following the COMMIT decision. Between commits they are stable.
- Illegal shape index values (3) recover to 0 at the next commit. Select outputs decode 3 as square.

Test Plan (DB_CYCLES=4, V_ACTIVE=480):
1. Reset low 3 clk, then high -> square_select=1, others 0, full_screen=0, pending=0, frame_update never pulses without a press.
2. btn_next high 10 clk at VCount=100 -> pending=1 within 2+4+1 clk. At VCount=480/HCount=0: one frame_update pulse, circle_select=1, square_select=0. No change before VCount=480.
3. Three btn_next presses in one frame -> single advance (square->circle). Three presses across three frames: square->circle->triangle->square (wrap).
4. btn_next and btn_full pressed the same frame from reset -> one commit: circle_select=1, full_screen=1. Repeat btn_full next frame -> full_screen=0.
5. btn_next glitch high 3 clk -> no request, pending stays 0, outputs unchanged.
6. Update condition held 2 clk (HCount=0 for 2 pixel-tick clk) with request pending -> exactly one frame_update. Reset asserted during WAIT_VB -> no commit; outputs return to reset values.
